// File: rtl/uart_rx_param_pkg.sv
// Shared UART receiver definitions: parity encodings, FSM states and the 3-sample vote.
// Intended to be reused by the matching transmitter.
package uart_rx_param_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous RX pin plus falling-edge detect.
// All flops reset to 1 so a line that idles high gives no edge after reset.
module uart_rx_sync (
  input  logic i_clk_sys,
  input  logic i_rst,
  input  logic i_rx,
  output logic rx_s,
  output logic fall_edge
);

  logic rx_meta;
  logic rx_s_d1;

  always_ff @(posedge i_clk_sys) begin
    if (i_rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_s_d1 <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
      rx_s_d1 <= rx_s;
    end
  end

  assign fall_edge = rx_s_d1 & ~rx_s;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with 3-sample majority vote, start-glitch rejection,
// parity/framing flags and an idle-gap burst delimiter.
//
// state     | meaning
// ST_IDLE   | line idle, waiting for a falling edge
// ST_START  | start bit; a high vote means a glitch and returns to idle
// ST_DATA   | shifting in DATA_BITS, LSB first
// ST_PARITY | parity bit check
// ST_STOP   | stop bit(s); leaves at mid-bit of the last one
// ST_BREAK  | line still low after the frame; wait for it to go high
module uart_rx_param
  import uart_rx_param_pkg::*;
#(
  parameter int CLK_FREQ      = 50_000_000,
  parameter int BAUD_RATE     = 9600,
  parameter int DATA_BITS     = 8,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1,
  parameter int IDLE_GAP_BITS = 0
) (
  input  logic                 i_clk_sys,
  input  logic                 i_rst,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_valid,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_busy,
  output logic                 o_idle_gap
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int HALF         = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int GAP_CLKS     = IDLE_GAP_BITS * CLKS_PER_BIT;
  localparam int GAP_W        = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] SMP_EARLY = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] SMP_MID   = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] SMP_LATE  = CNT_W'(HALF + 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

  logic                 rx_s;
  logic                 fall_edge;
  rx_state_t            state, state_nxt;
  logic [CNT_W-1:0]     baud_cnt;
  logic                 smp_early, smp_mid;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_err_acc, frm_err_acc;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid, parity_err, frame_err;
  logic                 decide, vote, exp_par, done;

  uart_rx_sync u_sync (
    .i_clk_sys (i_clk_sys),
    .i_rst     (i_rst),
    .i_rx      (i_rx),
    .rx_s      (rx_s),
    .fall_edge (fall_edge)
  );

  assign decide  = (baud_cnt == SMP_LATE);
  assign vote    = majority3(smp_early, smp_mid, rx_s);
  assign exp_par = (PARITY == PAR_ODD) ? ~^shreg : ^shreg;

  always_ff @(posedge i_clk_sys) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    unique case (state)
      ST_IDLE:   if (fall_edge) state_nxt = ST_START;
      ST_START:  if (decide) state_nxt = vote ? ST_IDLE : ST_DATA;
      ST_DATA:   if (decide && bit_cnt == DATA_LAST)
                   state_nxt = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
      ST_PARITY: if (decide) state_nxt = ST_STOP;
      ST_STOP:   if (decide && bit_cnt == STOP_LAST) begin
                   done      = 1'b1;
                   state_nxt = rx_s ? ST_IDLE : ST_BREAK;
                 end
      ST_BREAK:  if (rx_s) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk_sys) begin
    if (i_rst) begin
      baud_cnt    <= '0;
      smp_early   <= 1'b0;
      smp_mid     <= 1'b0;
      bit_cnt     <= '0;
      shreg       <= '0;
      par_err_acc <= 1'b0;
      frm_err_acc <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      // Held at zero in idle, so the first count after the edge is 0.
      if (state == ST_IDLE || baud_cnt == CNT_LAST) baud_cnt <= '0;
      else                                          baud_cnt <= baud_cnt + CNT_W'(1);

      if (baud_cnt == SMP_EARLY) smp_early <= rx_s;
      if (baud_cnt == SMP_MID)   smp_mid   <= rx_s;

      if (state != state_nxt) bit_cnt <= '0;
      else if (decide && (state == ST_DATA || state == ST_STOP)) bit_cnt <= bit_cnt + 4'd1;

      if (state == ST_START) begin
        par_err_acc <= 1'b0;
        frm_err_acc <= 1'b0;
      end
      if (state == ST_DATA && decide)                    shreg       <= {vote, shreg[DATA_BITS-1:1]};
      if (state == ST_PARITY && decide && vote != exp_par) par_err_acc <= 1'b1;
      if (state == ST_STOP && decide && !vote)           frm_err_acc <= 1'b1;

      rx_valid <= done;
      if (done) begin
        rx_data    <= shreg;
        parity_err <= par_err_acc;
        frame_err  <= frm_err_acc | ~vote;
      end
    end
  end

  generate
    if (IDLE_GAP_BITS > 0) begin : g_gap
      logic [GAP_W-1:0] gap_cnt;
      logic             armed;
      logic             gap_pulse;

      // A falling edge is checked before the threshold so it always wins.
      always_ff @(posedge i_clk_sys) begin
        if (i_rst) begin
          gap_cnt   <= '0;
          armed     <= 1'b0;
          gap_pulse <= 1'b0;
        end else begin
          gap_pulse <= 1'b0;
          if (rx_valid) begin
            gap_cnt <= '0;
            armed   <= 1'b1;
          end else if (fall_edge) begin
            gap_cnt <= '0;
          end else if (armed && state == ST_IDLE) begin
            if (gap_cnt == GAP_W'(GAP_CLKS - 1)) begin
              gap_pulse <= 1'b1;
              armed     <= 1'b0;
              gap_cnt   <= '0;
            end else begin
              gap_cnt <= gap_cnt + GAP_W'(1);
            end
          end
        end
      end

      assign o_idle_gap = gap_pulse;
    end else begin : g_no_gap
      assign o_idle_gap = 1'b0;
    end
  endgenerate

  assign o_rx_data    = rx_data;
  assign o_rx_valid   = rx_valid;
  assign o_parity_err = parity_err;
  assign o_frame_err  = frame_err;
  assign o_busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: four configurations side by side, directed cases plus
// random frames compared against a frame-level reference model.
module tb_uart_rx_param;

  localparam int CLK_HZ = 1_600_000;
  localparam int CPB_A  = 16;   // 100 kBd
  localparam int CPB_D  = 10;   // 160 kBd

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] rx  = 4'hF;
  logic [3:0] val, perr, ferr, busy, gap;
  logic [7:0] d0, d1, d2;
  logic [6:0] d3;
  logic [8:0] dat [4];

  int          n_vec = 0;
  int          n_err = 0;
  int unsigned cyc = 0;

  int          vcnt [4] = '{0, 0, 0, 0};
  int          gcnt [4] = '{0, 0, 0, 0};
  logic [8:0]  ldat [4];
  logic        lperr [4];
  logic        lferr [4];
  int unsigned vcyc [4];
  int unsigned gcyc [4];
  int unsigned tstart [4];

  int cfg_cpb [4]   = '{CPB_A, CPB_A, CPB_A, CPB_D};
  int cfg_nd [4]    = '{8, 8, 8, 7};
  int cfg_par [4]   = '{0, 2, 0, 1};
  int cfg_nstop [4] = '{1, 1, 1, 2};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_param #(.CLK_FREQ(CLK_HZ), .BAUD_RATE(100_000), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1), .IDLE_GAP_BITS(0)) u_8n1 (
    .i_clk_sys(clk), .i_rst(rst), .i_rx(rx[0]), .o_rx_data(d0), .o_rx_valid(val[0]),
    .o_parity_err(perr[0]), .o_frame_err(ferr[0]), .o_busy(busy[0]), .o_idle_gap(gap[0]));

  uart_rx_param #(.CLK_FREQ(CLK_HZ), .BAUD_RATE(100_000), .DATA_BITS(8), .PARITY(2),
                  .STOP_BITS(1), .IDLE_GAP_BITS(0)) u_8e1 (
    .i_clk_sys(clk), .i_rst(rst), .i_rx(rx[1]), .o_rx_data(d1), .o_rx_valid(val[1]),
    .o_parity_err(perr[1]), .o_frame_err(ferr[1]), .o_busy(busy[1]), .o_idle_gap(gap[1]));

  uart_rx_param #(.CLK_FREQ(CLK_HZ), .BAUD_RATE(100_000), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1), .IDLE_GAP_BITS(3)) u_gap (
    .i_clk_sys(clk), .i_rst(rst), .i_rx(rx[2]), .o_rx_data(d2), .o_rx_valid(val[2]),
    .o_parity_err(perr[2]), .o_frame_err(ferr[2]), .o_busy(busy[2]), .o_idle_gap(gap[2]));

  uart_rx_param #(.CLK_FREQ(CLK_HZ), .BAUD_RATE(160_000), .DATA_BITS(7), .PARITY(1),
                  .STOP_BITS(2), .IDLE_GAP_BITS(0)) u_7o2 (
    .i_clk_sys(clk), .i_rst(rst), .i_rx(rx[3]), .o_rx_data(d3), .o_rx_valid(val[3]),
    .o_parity_err(perr[3]), .o_frame_err(ferr[3]), .o_busy(busy[3]), .o_idle_gap(gap[3]));

  always_comb begin
    dat[0] = {1'b0, d0};
    dat[1] = {1'b0, d1};
    dat[2] = {1'b0, d2};
    dat[3] = {2'b00, d3};
  end

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (val[k]) begin
        vcnt[k]  = vcnt[k] + 1;
        ldat[k]  = dat[k];
        lperr[k] = perr[k];
        lferr[k] = ferr[k];
        vcyc[k]  = cyc;
      end
      if (gap[k]) begin
        gcnt[k] = gcnt[k] + 1;
        gcyc[k] = cyc;
      end
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Parity bit a correct transmitter would send for the given data.
  function automatic logic par_bit(input logic [8:0] d, input int nd, input int par);
    int ones = 0;
    for (int i = 0; i < nd; i++) ones += int'(d[i]);
    return (par == 2) ? logic'(ones % 2) : logic'((ones % 2) == 0);
  endfunction

  task automatic drive_bit(input int k, input logic b, input int n);
    rx[k] = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input int k, input logic [8:0] d, input logic pflip,
                            input logic [1:0] stops);
    tstart[k] = cyc;
    drive_bit(k, 1'b0, cfg_cpb[k]);
    for (int i = 0; i < cfg_nd[k]; i++) drive_bit(k, d[i], cfg_cpb[k]);
    if (cfg_par[k] != 0) drive_bit(k, par_bit(d, cfg_nd[k], cfg_par[k]) ^ pflip, cfg_cpb[k]);
    for (int i = 0; i < cfg_nstop[k]; i++) drive_bit(k, stops[i], cfg_cpb[k]);
  endtask

  task automatic frame_chk(input string tag, input int k, input logic [8:0] d,
                           input logic pflip, input logic [1:0] stops);
    int         v0;
    logic [8:0] exp_d;
    logic       exp_perr;
    logic       exp_ferr;
    v0       = vcnt[k];
    exp_d    = d & 9'((1 << cfg_nd[k]) - 1);
    exp_perr = (cfg_par[k] != 0) && pflip;
    exp_ferr = 1'b0;
    for (int i = 0; i < cfg_nstop[k]; i++) if (!stops[i]) exp_ferr = 1'b1;
    send_frame(k, d, pflip, stops);
    drive_bit(k, 1'b1, 2 * cfg_cpb[k]);
    check({tag, "_nvalid"}, vcnt[k], v0 + 1);
    check({tag, "_data"}, ldat[k], exp_d);
    check({tag, "_perr"}, lperr[k], exp_perr);
    check({tag, "_ferr"}, lferr[k], exp_ferr);
    check({tag, "_busy"}, busy[k], 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int          v0, g0, lat, exp_lat, gap_dly;
    int          k;
    logic [8:0]  rd;
    logic        pf;
    logic [1:0]  st;

    repeat (3) @(negedge clk);
    check("rst_ctrl_outputs", {val, perr, ferr, busy, gap}, 0);
    for (int i = 0; i < 4; i++) check($sformatf("rst_data%0d", i), dat[i], 0);
    rst = 1'b0;

    repeat (5 * CPB_A) @(negedge clk);
    check("gap_before_first_frame", gcnt[2], 0);

    frame_chk("t1_5a", 0, 9'h5A, 1'b0, 2'b11);

    frame_chk("t2_bad_parity", 1, 9'hA5, 1'b1, 2'b11);
    frame_chk("t2_good_parity", 1, 9'hA5, 1'b0, 2'b11);

    v0 = vcnt[0];
    send_frame(0, 9'h81, 1'b0, 2'b00);
    drive_bit(0, 1'b0, 20 * CPB_A);
    check("t3_single_valid", vcnt[0], v0 + 1);
    check("t3_data", ldat[0], 9'h81);
    check("t3_ferr", lferr[0], 1);
    check("t3_busy_while_low", busy[0], 1);
    drive_bit(0, 1'b1, 2 * CPB_A);
    check("t3_busy_released", busy[0], 0);
    frame_chk("t3_3c", 0, 9'h3C, 1'b0, 2'b11);

    v0 = vcnt[0];
    drive_bit(0, 1'b0, CPB_A / 4);
    drive_bit(0, 1'b1, CPB_A);
    check("t4_glitch_busy", busy[0], 0);
    drive_bit(0, 1'b1, CPB_A);
    check("t4_glitch_no_valid", vcnt[0], v0);
    frame_chk("t4_11", 0, 9'h11, 1'b0, 2'b11);

    v0 = vcnt[2];
    g0 = gcnt[2];
    send_frame(2, 9'h00, 1'b0, 2'b11);
    check("t5_first_data", ldat[2], 9'h00);
    send_frame(2, 9'hFF, 1'b0, 2'b11);
    check("t5_no_gap_between", gcnt[2], g0);
    check("t5_two_valids", vcnt[2], v0 + 2);
    check("t5_second_data", ldat[2], 9'hFF);
    drive_bit(2, 1'b1, 4 * CPB_A);
    check("t5_one_gap", gcnt[2], g0 + 1);
    gap_dly = int'(gcyc[2]) - int'(vcyc[2]);
    check($sformatf("t5_gap_delay_%0d", gap_dly),
          int'(gap_dly >= 3 * CPB_A - 2 && gap_dly <= 3 * CPB_A + 2), 1);
    drive_bit(2, 1'b1, 4 * CPB_A);
    check("t5_gap_disarmed", gcnt[2], g0 + 1);

    v0 = vcnt[0];
    rd = 9'h77;
    drive_bit(0, 1'b0, CPB_A);
    for (int i = 0; i < 4; i++) drive_bit(0, rd[i], CPB_A);
    drive_bit(0, rd[4], CPB_A / 2);
    check("t6_busy_mid_frame", busy[0], 1);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_ctrl", {val[0], perr[0], ferr[0], busy[0], gap[0]}, 0);
    check("t6_rst_data", dat[0], 0);
    rx[0] = 1'b1;
    rst = 1'b0;
    repeat (12 * CPB_A) @(negedge clk);
    check("t6_no_valid", vcnt[0], v0);
    frame_chk("t6_77", 0, 9'h77, 1'b0, 2'b11);

    frame_chk("t7_55", 3, 9'h55, 1'b0, 2'b11);
    lat     = int'(vcyc[3]) - int'(tstart[3] + 1);
    exp_lat = 2 + (1 + 7 + 1 + 2 - 1) * CPB_D + CPB_D / 2 + 2;
    check($sformatf("t7_latency_%0d_vs_%0d", lat, exp_lat),
          int'(lat >= exp_lat - 1 && lat <= exp_lat + 1), 1);

    for (int n = 0; n < 16; n++) begin
      k  = int'($urandom_range(0, 3));
      rd = 9'($urandom);
      pf = (cfg_par[k] != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      st = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
      frame_chk($sformatf("rnd%0d_u%0d", n, k), k, rd, pf, st);
    end

    check("no_gap_when_disabled", gcnt[0] + gcnt[1] + gcnt[3], 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
